// File: rtl/alu_arbiter_if.sv
// Request/response channels for two requesters plus the shared ALU bus of alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters/ALU side.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_out;
  logic [2:0]        rsp0_flags;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_out;
  logic [2:0]        rsp1_flags;

  logic [DATA_W-1:0] alu_port_a;
  logic [DATA_W-1:0] alu_port_b;
  logic [OP_W-1:0]   alu_aluop;
  logic [DATA_W-1:0] alu_port_out;
  logic              alu_negative;
  logic              alu_overflow;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp0_out, rsp0_flags,
    input  rsp0_ready,
    output rsp1_valid, rsp1_out, rsp1_flags,
    input  rsp1_ready,
    output alu_port_a, alu_port_b, alu_aluop,
    input  alu_port_out, alu_negative, alu_overflow, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp0_out, rsp0_flags,
    output rsp0_ready,
    input  rsp1_valid, rsp1_out, rsp1_flags,
    output rsp1_ready,
    input  alu_port_a, alu_port_b, alu_aluop,
    output alu_port_out, alu_negative, alu_overflow, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between execute (0) and debug (1) requesters.
// Optional macro ALU_ARB_TIMEOUT_EN adds a response-hold timeout with a sticky err flag.
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  alu_arbiter_if.slave  bus,
  output logic          busy,
  output logic          grant_id,
  output logic          err
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("alu_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              prio_q;
  logic              grant_q;
  logic              win;
  logic              accept;
  logic              hs;
  logic              tmo;

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [OP_W-1:0]   op_p0;
  logic [DATA_W-1:0] out0_p1;
  logic [DATA_W-1:0] out1_p1;
  logic [2:0]        flags0_p1;
  logic [2:0]        flags1_p1;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tmo     = 1'b0;
    win     = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    hs      = (state_q == RESP) && (grant_q ? bus.rsp1_ready : bus.rsp0_ready);
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (hs) begin
          state_d = IDLE;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: operand capture on accept; stage p1: result capture in EXEC
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      grant_q   <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
      op_p0     <= '0;
      out0_p1   <= '0;
      out1_p1   <= '0;
      flags0_p1 <= '0;
      flags1_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= win;
        prio_q  <= ~win;
        a_p0    <= win ? bus.req1_a  : bus.req0_a;
        b_p0    <= win ? bus.req1_b  : bus.req0_b;
        op_p0   <= win ? bus.req1_op : bus.req0_op;
      end else if (tmo) begin
        prio_q  <= ~grant_q;
      end
      if (state_q == EXEC) begin
        if (grant_q) begin
          out1_p1   <= bus.alu_port_out;
          flags1_p1 <= {bus.alu_negative, bus.alu_overflow, bus.alu_zero};
        end else begin
          out0_p1   <= bus.alu_port_out;
          flags0_p1 <= {bus.alu_negative, bus.alu_overflow, bus.alu_zero};
        end
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  // Counter restarts on every entry to RESP; err is sticky until reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == EXEC) begin
        cnt_q <= '0;
      end else if (state_q == RESP && !hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.req0_ready = accept && !win;
  assign bus.req1_ready = accept && win;
  assign bus.rsp0_valid = (state_q == RESP) && !grant_q;
  assign bus.rsp1_valid = (state_q == RESP) && grant_q;
  assign bus.rsp0_out   = out0_p1;
  assign bus.rsp0_flags = flags0_p1;
  assign bus.rsp1_out   = out1_p1;
  assign bus.rsp1_flags = flags1_p1;
  assign bus.alu_port_a = a_p0;
  assign bus.alu_port_b = b_p0;
  assign bus.alu_aluop  = op_p0;
  assign busy           = (state_q != IDLE);
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus
// hand-written latency, contention, backpressure, reset and timeout sequences.
module tb_alu_arbiter;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic CLK = 1'b0;
  logic RST;
  logic busy;
  logic grant_id;
  logic err;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

  alu_arbiter #(.DATA_W(32), .OP_W(4), .TIMEOUT(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU stub attached to the shared ALU bus
  logic [31:0] alu_res;
  logic        alu_ovf;
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alu_aluop)
      OP_ADD: begin
        alu_res = bus.alu_port_a + bus.alu_port_b;
        alu_ovf = (bus.alu_port_a[31] == bus.alu_port_b[31]) && (alu_res[31] != bus.alu_port_a[31]);
      end
      OP_SUB: begin
        alu_res = bus.alu_port_a - bus.alu_port_b;
        alu_ovf = (bus.alu_port_a[31] != bus.alu_port_b[31]) && (alu_res[31] != bus.alu_port_a[31]);
      end
      OP_AND: alu_res = bus.alu_port_a & bus.alu_port_b;
      OP_OR:  alu_res = bus.alu_port_a | bus.alu_port_b;
      OP_XOR: alu_res = bus.alu_port_a ^ bus.alu_port_b;
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_port_out = alu_res;
  assign bus.alu_negative = alu_res[31];
  assign bus.alu_overflow = alu_ovf;
  assign bus.alu_zero     = (alu_res == 32'd0);

  typedef struct {
    int          r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [2:0]  flags;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int r, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Called just after a falling edge; returns at the falling edge of the EXEC cycle
  task automatic send(input int r, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, output int waited);
    logic got;
    got    = 1'b0;
    waited = 0;
    drive_req(r, 1'b1, op, a, b);
    while (!got && waited < 20) begin
      #1;
      got = (r == 0) ? bus.req0_ready : bus.req1_ready;
      @(negedge CLK);
      if (!got) waited++;
    end
    drive_req(r, 1'b0, op, a, b);
    chk("accept_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input int r, output logic [31:0] out, output logic [2:0] flags,
                          output logic other);
    logic got;
    got = 1'b0; out = '0; flags = '0; other = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if ((r == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
        got   = 1'b1;
        out   = (r == 0) ? bus.rsp0_out   : bus.rsp1_out;
        flags = (r == 0) ? bus.rsp0_flags : bus.rsp1_flags;
        other = (r == 0) ? bus.rsp1_valid : bus.rsp0_valid;
      end
      @(negedge CLK);
    end
    chk("rsp_seen", 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] out;
    logic [2:0]  flags;
    logic        other;
    int          waited;
    int          idx;
    int          n;

    vecs[0] = '{0, OP_ADD, 32'd5,          32'd3,          32'd8,          3'b000};
    vecs[1] = '{0, OP_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  3'b110};
    vecs[2] = '{1, OP_SUB, 32'd3,          32'd3,          32'd0,          3'b001};
    vecs[3] = '{1, OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  3'b100};
    vecs[4] = '{0, OP_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  3'b010};
    vecs[5] = '{1, OP_AND, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  3'b000};
    vecs[6] = '{0, OP_XOR, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          3'b001};
    vecs[7] = '{1, OP_OR,  32'h8000_0000,  32'd1,          32'h8000_0001,  3'b100};

    RST = 1'b1;
    drive_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drive_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    chk("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    chk("rst_rsp_out", bus.rsp0_out | bus.rsp1_out, 32'd0);
    chk("rst_flags", 32'({bus.rsp0_flags, bus.rsp1_flags}), 32'd0);
    chk("rst_alu", bus.alu_port_a | bus.alu_port_b | 32'(bus.alu_aluop), 32'd0);
    chk("rst_ctrl", 32'({busy, grant_id, err}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Latency and busy profile of one ADD with one stalled response cycle
    drive_req(0, 1'b1, OP_ADD, 32'd5, 32'd3);
    #1;
    chk("lat_ready_t0", 32'({bus.req0_ready, bus.req1_ready, busy}), 32'b100);
    @(negedge CLK);
    drive_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    chk("lat_exec_busy_valid", 32'({busy, bus.rsp0_valid}), 32'b10);
    chk("lat_alu_a", bus.alu_port_a, 32'd5);
    chk("lat_alu_b", bus.alu_port_b, 32'd3);
    @(negedge CLK);
    #1;
    chk("lat_rsp_valid_t2", 32'({bus.rsp0_valid, bus.rsp1_valid, busy, grant_id}), 32'b1010);
    chk("lat_rsp_out", bus.rsp0_out, 32'd8);
    chk("lat_rsp_flags", 32'(bus.rsp0_flags), 32'd0);
    @(negedge CLK);
    bus.rsp0_ready = 1'b1;
    #1;
    chk("lat_hold_t3", 32'({bus.rsp0_valid, busy}), 32'b11);
    @(negedge CLK);
    #1;
    chk("lat_idle_t4", 32'({bus.rsp0_valid, busy}), 32'b00);
    @(negedge CLK);

    // Table of single-requester operations
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, waited);
      wait_rsp(vecs[i].r, out, flags, other);
      chk($sformatf("vec%0d_out", i), out, vecs[i].out);
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].flags));
      chk($sformatf("vec%0d_other_valid", i), 32'(other), 32'd0);
    end

    // Contention: both valid from reset, grants alternate starting at 0
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    drive_req(1, 1'b1, OP_ADD, 32'd10, 32'd20);
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      #1;
      if (bus.rsp0_valid) begin
        chk("cont_rsp0_out", bus.rsp0_out, 32'd2);
        chk("cont_rsp0_excl", 32'(bus.rsp1_valid), 32'd0);
      end
      if (bus.rsp1_valid) begin
        chk("cont_rsp1_out", bus.rsp1_out, 32'd30);
        chk("cont_rsp1_excl", 32'(bus.rsp0_valid), 32'd0);
      end
      if (bus.req0_ready || bus.req1_ready) begin
        chk("cont_grant_order", 32'(bus.req1_ready), 32'(idx % 2));
        chk("cont_one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        idx++;
      end
      @(negedge CLK);
    end
    drive_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drive_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    chk("cont_grant_count", 32'(idx), 32'd4);
    wait_rsp(1, out, flags, other);
    chk("cont_last_out", out, 32'd30);

    // Backpressure on requester 1 while requester 0 waits
    bus.rsp1_ready = 1'b0;
    send(1, OP_SUB, 32'd3, 32'd3, waited);
    drive_req(0, 1'b1, OP_ADD, 32'd2, 32'd2);
    #1;
    chk("bp_ready_exec", 32'(bus.req0_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      #1;
      chk("bp_valid", 32'(bus.rsp1_valid), 32'd1);
      chk("bp_out", bus.rsp1_out, 32'd0);
      chk("bp_flags", 32'(bus.rsp1_flags), 32'b001);
      chk("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
    end
    @(negedge CLK);
    bus.rsp1_ready = 1'b1;
    #1;
    chk("bp_hs_cycle", 32'({bus.rsp1_valid, bus.req0_ready}), 32'b10);
    @(negedge CLK);
    #1;
    chk("bp_after_hs", 32'({bus.rsp1_valid, bus.req0_ready}), 32'b01);
    @(negedge CLK);
    drive_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    wait_rsp(0, out, flags, other);
    chk("bp_req0_out", out, 32'd4);

    // Reset in EXEC discards the in-flight result
    send(0, OP_ADD, 32'd9, 32'd9, waited);
    RST = 1'b1;
    #1;
    chk("rmid_ctrl", 32'({busy, grant_id, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    chk("rmid_rsp0_out", bus.rsp0_out, 32'd0);
    chk("rmid_alu_a", bus.alu_port_a, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.rsp0_valid || bus.rsp1_valid) n++;
      @(negedge CLK);
    end
    chk("rmid_no_rsp", 32'(n), 32'd0);
    drive_req(0, 1'b1, OP_ADD, 32'd0, 32'd0);
    drive_req(1, 1'b1, OP_ADD, 32'd0, 32'd0);
    #1;
    chk("rmid_prio_reset", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
    drive_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drive_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    @(negedge CLK);
    #1;
    chk("drop_no_accept", 32'(busy), 32'd0);
    @(negedge CLK);
    send(1, OP_ADD, 32'd1, 32'd2, waited);
    chk("rmid_req1_first", 32'(waited), 32'd0);
    wait_rsp(1, out, flags, other);
    chk("rmid_req1_out", out, 32'd3);

`ifdef ALU_ARB_TIMEOUT_EN
    bus.rsp0_ready = 1'b0;
    send(0, OP_ADD, 32'd1, 32'd1, waited);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      #1;
      if (bus.rsp0_valid) n++;
      else if (n > 0) break;
    end
    chk("tmo_valid_cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(err), 32'd1);
    repeat (2) @(negedge CLK);
    #1;
    chk("tmo_err_sticky", 32'({err, busy}), 32'b10);
    @(negedge CLK);
    drive_req(0, 1'b1, OP_ADD, 32'd0, 32'd0);
    drive_req(1, 1'b1, OP_ADD, 32'd4, 32'd4);
    #1;
    chk("tmo_prio_flip", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
    @(negedge CLK);
    drive_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drive_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    bus.rsp1_ready = 1'b1;
    wait_rsp(1, out, flags, other);
    chk("tmo_req1_out", out, 32'd8);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
